imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator in the RISC_V_64_bit_Single_Cycle_CPU.
- Decodes the immediate for RV32I/RV64I formats (I, S, B, U, J, shift-amount, CSR zimm) at width XLEN.
- Also emits a format code and an illegal-opcode flag.
- Sits between fetch and execute behind a valid/ready handshake, with a 2-entry skid buffer so stalls never drop or duplicate instructions.

Parameters:
- XLEN, 64, datapath width; legal values are 32 and 64 only. Any other value triggers a $error at elaboration.
- TAG_W, 8, width of the opaque sideband tag (e.g. PC index) carried alongside each instruction.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  instruction valid.
- in_ready  output  1  block can accept this cycle.
- in_instr  input  32  instruction word.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- out_imm  output  XLEN  decoded immediate.
- out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 Z.
- out_illegal  output  1  opcode is not recognised for this XLEN.
- out_instr  output  32  instruction, passed through.
- out_tag  output  TAG_W  tag, passed through.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low clears both entries asynchronously.
  - Reset values: out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_instr=0, out_tag=0.
- Decode (combinational on in_instr, registered on accept). Opcode is in_instr[6:0].
  - 0000011 (load), 1100111 (jalr), 0010011 (op-imm) with funct3 not in {001,101}: fmt I, imm = sext(instr[31:20]).
  - 0010011 with funct3 001 or 101: fmt SHAMT.
    - XLEN=64: imm = zext(instr[25:20]).
    - XLEN=32: imm = zext(instr[24:20]); instr[25]=1 sets illegal.
  - 0011011 (op-imm-32), XLEN=64 only: funct3 001/101 gives SHAMT with imm = zext(instr[24:20]); otherwise I. Under XLEN=32 this opcode is illegal.
  - 0100011: fmt S, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011: fmt B, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111 / 0010111: fmt U, imm = sext({instr[31:12], 12'b0}) to XLEN.
  - 1101111: fmt J, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 1110011 with funct3[2]=1: fmt Z, imm = zext(instr[19:15]).
  - 1110011 with funct3[2]=0: fmt NONE, imm 0, not illegal.
  - 0110011 / 0111011 (R-type; 0111011 is XLEN=64 only): fmt NONE, imm 0, not illegal.
  - Any other opcode: fmt NONE, imm 0, out_illegal=1.
- Pipeline / handshake:
  - Two entries: OUT (drives the outputs) and SKID.
  - Transfer occurs when in_valid&&in_ready (input side) or out_valid&&out_ready (output side).
  - in_ready is registered and equals !SKID.valid. It is never combinationally dependent on out_ready.
  - Latency: an instruction accepted at cycle N is visible on the outputs at cycle N+1 when OUT is empty or drains at N.
  - Accept while OUT is empty or draining: the decoded word loads OUT.
  - Accept while OUT is full and stalled: the word loads SKID, and in_ready drops next cycle.
  - OUT drains while SKID is full: SKID moves to OUT and SKID clears.
  - OUT drains while SKID is full and a new word is accepted: not possible, because in_ready=0.
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - Ordering is strictly FIFO.
- Flush:
  - Next cycle: both entries are invalid and in_ready=1.
  - Any word presented in the flush cycle is dropped, even if it was accepted.
  - flush has priority over all transfers.
- Reset asserted mid-transfer: contents are lost immediately and out_valid falls asynchronously.
- Widths: all sign extension replicates the source MSB to XLEN. U-type under XLEN=32 has no extension.

Test Plan:
- XLEN=64: ADDI x1,x0,-1 (0xFFF00093), out_ready=1 → one cycle later out_imm=FFFFFFFFFFFFFFFF, fmt=1, illegal=0.
- XLEN=64, back-to-back:
  - SRAI x1,x1,63 (0x43F0D093) → imm=000000000000003F, fmt=6.
  - BEQ -4 (0xFE000EE3) → imm=FFFFFFFFFFFFFFFC, fmt=3.
  - CSRRWI (0x300FD073) → imm=000000000000001F, fmt=7.
- LUI x1,0x80000 (0x800000B7):
  - XLEN=64 → imm=FFFFFFFF80000000.
  - XLEN=32 → imm=80000000.
- Backpressure:
  - Hold out_ready=0 and send tags 1,2,3 with in_valid=1 → in_ready falls after 2 accepts, and tag 3 is held at the input.
  - Release out_ready → tags emerge 1,2,3 in order with no loss or duplicates.
- Illegal opcodes:
  - 0x0000007F → out_illegal=1, fmt=0, imm=0.
  - XLEN=32 with 0x0000001B → illegal=1.
- With both entries full:
  - Assert flush for 1 cycle → out_valid=0 and in_ready=1 next cycle.
  - Assert rst_n low mid-stream → out_valid=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// Fetch-to-execute handshake bundle for the pipelined immediate generator.
// The slave side is the decoder; the master side is the fetch/execute environment.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [2:0]        out_fmt;
    logic              out_illegal;
    logic [31:0]       out_instr;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate decoder with format code, illegal flag and
// a two-entry (OUT + SKID) buffer behind a valid/ready handshake.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_Z     = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t      w_dec, r_out, r_skid, w_out_nxt, w_skid_nxt;
    logic        r_out_v, r_skid_v, r_in_ready;
    logic        w_out_v_nxt, w_skid_v_nxt;
    logic        w_acc, w_drain, w_shift;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;

    assign w_op    = bus.in_instr[6:0];
    assign w_f3    = bus.in_instr[14:12];
    assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    // Immediate decode of the word currently presented at the input
    always_comb begin
        w_dec         = '0;
        w_dec.instr   = bus.in_instr;
        w_dec.tag     = bus.in_tag;
        case (w_op)
            OP_LOAD, OP_JALR: begin
                w_dec.fmt = FMT_I;
                w_dec.imm = XLEN'($signed(bus.in_instr[31:20]));
            end
            OP_IMM: begin
                if (w_shift) begin
                    w_dec.fmt = FMT_SHAMT;
                    if (XLEN == 64) begin
                        w_dec.imm = XLEN'(bus.in_instr[25:20]);
                    end else begin
                        w_dec.imm     = XLEN'(bus.in_instr[24:20]);
                        w_dec.illegal = bus.in_instr[25];
                    end
                end else begin
                    w_dec.fmt = FMT_I;
                    w_dec.imm = XLEN'($signed(bus.in_instr[31:20]));
                end
            end
            OP_IMM32: begin
                if (XLEN != 64) begin
                    w_dec.illegal = 1'b1;
                end else if (w_shift) begin
                    w_dec.fmt = FMT_SHAMT;
                    w_dec.imm = XLEN'(bus.in_instr[24:20]);
                end else begin
                    w_dec.fmt = FMT_I;
                    w_dec.imm = XLEN'($signed(bus.in_instr[31:20]));
                end
            end
            OP_STORE: begin
                w_dec.fmt = FMT_S;
                w_dec.imm = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
            end
            OP_BRANCH: begin
                w_dec.fmt = FMT_B;
                w_dec.imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[7],
                                           bus.in_instr[30:25], bus.in_instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                w_dec.fmt = FMT_U;
                w_dec.imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                w_dec.fmt = FMT_J;
                w_dec.imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12],
                                           bus.in_instr[20], bus.in_instr[30:21], 1'b0}));
            end
            OP_SYSTEM: begin
                if (w_f3[2]) begin
                    w_dec.fmt = FMT_Z;
                    w_dec.imm = XLEN'(bus.in_instr[19:15]);
                end
            end
            OP_REG:   w_dec.fmt = FMT_NONE;
            OP_REG32: w_dec.illegal = (XLEN != 64);
            default:  w_dec.illegal = 1'b1;
        endcase
    end

    assign w_acc   = bus.in_valid && r_in_ready;
    assign w_drain = r_out_v && bus.out_ready;

    // OUT/SKID next state; SKID only fills when OUT is full and stalled
    always_comb begin
        w_out_nxt    = r_out;
        w_skid_nxt   = r_skid;
        w_out_v_nxt  = r_out_v;
        w_skid_v_nxt = r_skid_v;
        if (flush) begin
            w_out_v_nxt  = 1'b0;
            w_skid_v_nxt = 1'b0;
        end else if (w_drain || !r_out_v) begin
            if (r_skid_v) begin
                w_out_nxt    = r_skid;
                w_out_v_nxt  = 1'b1;
                w_skid_v_nxt = 1'b0;
            end else if (w_acc) begin
                w_out_nxt   = w_dec;
                w_out_v_nxt = 1'b1;
            end else begin
                w_out_v_nxt = 1'b0;
            end
        end else if (w_acc) begin
            w_skid_nxt   = w_dec;
            w_skid_v_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_skid     <= '0;
            r_out_v    <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_out      <= w_out_nxt;
            r_skid     <= w_skid_nxt;
            r_out_v    <= w_out_v_nxt;
            r_skid_v   <= w_skid_v_nxt;
            r_in_ready <= !w_skid_v_nxt;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_v;
    assign bus.out_imm     = r_out.imm;
    assign bus.out_fmt     = r_out.fmt;
    assign bus.out_illegal = r_out.illegal;
    assign bus.out_instr   = r_out.instr;
    assign bus.out_tag     = r_out.tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share one stimulus
// stream and are checked against a queue-based reference model.
module tb_imm_gen_pipe;
    localparam int unsigned TAG_W = 8;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) if64 ();
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) if32 ();

    assign if64.in_valid  = in_valid;
    assign if64.in_instr  = in_instr;
    assign if64.in_tag    = in_tag;
    assign if64.out_ready = out_ready;
    assign if32.in_valid  = in_valid;
    assign if32.in_instr  = in_instr;
    assign if32.in_tag    = in_tag;
    assign if32.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64));
    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32));

    int errors = 0;
    int checks = 0;

    typedef struct { logic [31:0] instr; logic [7:0] tag; } item_t;
    item_t q[$];

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm64; logic [2:0] fmt64; logic ill64;
        logic [31:0] imm32; logic [2:0] fmt32; logic ill32;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input longint raw, input int bits);
        longint m;
        m = longint'(1) << (bits - 1);
        return (raw ^ m) - m;
    endfunction

    // Reference decode straight from the ISA field layouts
    function automatic void ref_decode(input logic [31:0] ins, input bit rv64,
                                       output logic [63:0] imm, output logic [2:0] fmt,
                                       output logic ill);
        longint v;
        logic [2:0] f3;
        bit sh;
        f3 = ins[14:12];
        sh = (f3 == 3'd1) || (f3 == 3'd5);
        v = 0; fmt = 3'd0; ill = 1'b0;
        case (ins[6:0])
            7'h03, 7'h67: begin fmt = 3'd1; v = sx(longint'(ins[31:20]), 12); end
            7'h13: begin
                if (sh) begin
                    fmt = 3'd6;
                    if (rv64) v = longint'(ins[25:20]);
                    else begin v = longint'(ins[24:20]); ill = ins[25]; end
                end else begin fmt = 3'd1; v = sx(longint'(ins[31:20]), 12); end
            end
            7'h1B: begin
                if (!rv64) ill = 1'b1;
                else if (sh) begin fmt = 3'd6; v = longint'(ins[24:20]); end
                else begin fmt = 3'd1; v = sx(longint'(ins[31:20]), 12); end
            end
            7'h23: begin fmt = 3'd2; v = sx((longint'(ins[31:25]) << 5) | longint'(ins[11:7]), 12); end
            7'h63: begin
                fmt = 3'd3;
                v = sx((longint'(ins[31]) << 12) | (longint'(ins[7]) << 11) |
                       (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1), 13);
            end
            7'h37, 7'h17: begin fmt = 3'd4; v = sx(longint'(ins[31:12]) * 4096, 32); end
            7'h6F: begin
                fmt = 3'd5;
                v = sx((longint'(ins[31]) << 20) | (longint'(ins[19:12]) << 12) |
                       (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1), 21);
            end
            7'h73: if (f3[2]) begin fmt = 3'd7; v = longint'(ins[19:15]); end
            7'h33: ;
            7'h3B: ill = !rv64;
            default: ill = 1'b1;
        endcase
        imm = 64'(v);
    endfunction

    task automatic check_state();
        logic [63:0] imm; logic [2:0] fmt; logic ill;
        chk("out_valid64", 64'(if64.out_valid), 64'(q.size() > 0));
        chk("in_ready64",  64'(if64.in_ready),  64'(q.size() < 2));
        chk("out_valid32", 64'(if32.out_valid), 64'(q.size() > 0));
        chk("in_ready32",  64'(if32.in_ready),  64'(q.size() < 2));
        if (q.size() > 0) begin
            ref_decode(q[0].instr, 1'b1, imm, fmt, ill);
            chk("imm64", if64.out_imm, imm);
            chk("fmt64", 64'(if64.out_fmt), 64'(fmt));
            chk("ill64", 64'(if64.out_illegal), 64'(ill));
            chk("instr64", 64'(if64.out_instr), 64'(q[0].instr));
            chk("tag64", 64'(if64.out_tag), 64'(q[0].tag));
            ref_decode(q[0].instr, 1'b0, imm, fmt, ill);
            chk("imm32", 64'(if32.out_imm), 64'(imm[31:0]));
            chk("fmt32", 64'(if32.out_fmt), 64'(fmt));
            chk("ill32", 64'(if32.out_illegal), 64'(ill));
            chk("tag32", 64'(if32.out_tag), 64'(q[0].tag));
        end
    endtask

    // Present inputs for one cycle (called at negedge), advance model, check.
    task automatic drive(input bit v, input logic [31:0] ins, input logic [7:0] tg,
                         input bit ordy, input bit fl);
        bit acc, drn;
        in_valid = v; in_instr = ins; in_tag = tg; out_ready = ordy; flush = fl;
        acc = v && (q.size() < 2);
        drn = ordy && (q.size() > 0);
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back('{ins, tg});
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    initial begin
        logic [6:0]  ops[12];
        logic [31:0] r;
        ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B};

        tbl[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 3'd1, 1'b0};
        tbl[1]  = '{32'h43F0D093, 64'h000000000000003F, 3'd6, 1'b0, 32'h0000001F, 3'd6, 1'b1};
        tbl[2]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 32'hFFFFFFFC, 3'd3, 1'b0};
        tbl[3]  = '{32'h300FD073, 64'h000000000000001F, 3'd7, 1'b0, 32'h0000001F, 3'd7, 1'b0};
        tbl[4]  = '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 32'h80000000, 3'd4, 1'b0};
        tbl[5]  = '{32'h0000007F, 64'h0,                3'd0, 1'b1, 32'h0,        3'd0, 1'b1};
        tbl[6]  = '{32'h0000001B, 64'h0,                3'd1, 1'b0, 32'h0,        3'd0, 1'b1};
        tbl[7]  = '{32'hFE112C23, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0, 32'hFFFFFFF8, 3'd2, 1'b0};
        tbl[8]  = '{32'h00000073, 64'h0,                3'd0, 1'b0, 32'h0,        3'd0, 1'b0};
        tbl[9]  = '{32'h002080B3, 64'h0,                3'd0, 1'b0, 32'h0,        3'd0, 1'b0};
        tbl[10] = '{32'h0000003B, 64'h0,                3'd0, 1'b0, 32'h0,        3'd0, 1'b1};
        tbl[11] = '{32'h0010006F, 64'h0000000000000800, 3'd5, 1'b0, 32'h00000800, 3'd5, 1'b0};
        tbl[12] = '{32'h01F0909B, 64'h000000000000001F, 3'd6, 1'b0, 32'h0,        3'd0, 1'b1};
        tbl[13] = '{32'h12345017, 64'h0000000012345000, 3'd4, 1'b0, 32'h12345000, 3'd4, 1'b0};
        tbl[14] = '{32'hFFF0C093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 3'd1, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_tag = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(if64.out_valid), 64'd0);
        chk("rst_in_ready",  64'(if64.in_ready),  64'd1);
        chk("rst_imm",       if64.out_imm,        64'd0);
        chk("rst_fmt",       64'(if64.out_fmt),   64'd0);
        chk("rst_ill",       64'(if64.out_illegal), 64'd0);
        chk("rst_instr",     64'(if64.out_instr), 64'd0);
        chk("rst_tag",       64'(if64.out_tag),   64'd0);
        chk("rst_in_ready32", 64'(if32.in_ready), 64'd1);
        rst_n = 1'b1;

        // Back-to-back table vectors with the consumer always ready
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, tbl[i].instr, 8'(i + 16), 1'b1, 1'b0);
            chk($sformatf("vec%0d_imm64", i), if64.out_imm, tbl[i].imm64);
            chk($sformatf("vec%0d_fmt64", i), 64'(if64.out_fmt), 64'(tbl[i].fmt64));
            chk($sformatf("vec%0d_ill64", i), 64'(if64.out_illegal), 64'(tbl[i].ill64));
            chk($sformatf("vec%0d_imm32", i), 64'(if32.out_imm), 64'(tbl[i].imm32));
            chk($sformatf("vec%0d_fmt32", i), 64'(if32.out_fmt), 64'(tbl[i].fmt32));
            chk($sformatf("vec%0d_ill32", i), 64'(if32.out_illegal), 64'(tbl[i].ill32));
        end
        drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Backpressure: tags 1,2,3 with the consumer stalled
        drive(1'b1, 32'hFFF00093, 8'd1, 1'b0, 1'b0);
        chk("bp_ready_after1", 64'(if64.in_ready), 64'd1);
        drive(1'b1, 32'h43F0D093, 8'd2, 1'b0, 1'b0);
        chk("bp_ready_after2", 64'(if64.in_ready), 64'd0);
        drive(1'b1, 32'hFE000EE3, 8'd3, 1'b0, 1'b0);
        chk("bp_hold_tag", 64'(if64.out_tag), 64'd1);
        chk("bp_hold_ready", 64'(if64.in_ready), 64'd0);
        drive(1'b1, 32'hFE000EE3, 8'd3, 1'b1, 1'b0);
        chk("bp_emit2", 64'(if64.out_tag), 64'd2);
        drive(1'b1, 32'hFE000EE3, 8'd3, 1'b1, 1'b0);
        chk("bp_emit3", 64'(if64.out_tag), 64'd3);
        drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
        chk("bp_drained", 64'(if64.out_valid), 64'd0);

        // Flush with both entries full, and flush on an accepting cycle
        drive(1'b1, 32'h800000B7, 8'd4, 1'b0, 1'b0);
        drive(1'b1, 32'h300FD073, 8'd5, 1'b0, 1'b0);
        drive(1'b1, 32'hFFF00093, 8'd6, 1'b0, 1'b1);
        chk("flush_valid", 64'(if64.out_valid), 64'd0);
        chk("flush_ready", 64'(if64.in_ready), 64'd1);
        drive(1'b1, 32'h800000B7, 8'd7, 1'b0, 1'b0);
        drive(1'b1, 32'h300FD073, 8'd8, 1'b1, 1'b1);
        chk("flush_acc_valid", 64'(if64.out_valid), 64'd0);
        chk("flush_acc_valid32", 64'(if32.out_valid), 64'd0);

        // Asynchronous reset while both entries are full
        drive(1'b1, 32'h800000B7, 8'd9, 1'b0, 1'b0);
        drive(1'b1, 32'h300FD073, 8'd10, 1'b0, 1'b0);
        in_valid = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid64", 64'(if64.out_valid), 64'd0);
        chk("arst_valid32", 64'(if32.out_valid), 64'd0);
        chk("arst_ready", 64'(if64.in_ready), 64'd1);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_state();

        // Randomised traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            r = $urandom();
            if ($urandom_range(0, 9) == 0)
                drive(($urandom_range(0, 3) != 0), r, 8'($urandom()), ($urandom_range(0, 2) != 0),
                      ($urandom_range(0, 49) == 0));
            else
                drive(($urandom_range(0, 3) != 0), {r[31:7], ops[$urandom_range(0, 11)]},
                      8'($urandom()), ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
